// File: rtl/fpu_wb_scheduler.sv
// rtl/fpu_wb_scheduler.sv - FP issue and writeback-port scheduler for the execute stage
//
// Purpose:
//   Accepts at most one FP op per cycle and reserves the single FP writeback
//   port ahead of time. A 16-entry slot array is used as a time wheel: slot k
//   describes the writeback happening k cycles from now. Issue stalls when the
//   slot the op would need is already taken, or when the non-pipelined divider
//   is still busy.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   issue_valid        execute stage presents an FP op
//   issue_op[3:0]      1010 fneg, 1011 fadd, 1100 fsub, 1101 fmul, 1110 fdiv
//   issue_tag          destination register tag
//   issue_ready        combinational accept for the current op
//   stall              issue_valid & ~issue_ready
//   flush              kill every in-flight op (wins over a same-cycle issue)
//   addsub_sel         registered add/sub unit control: 1 add, 0 sub
//   wb_valid           result on the FP writeback port this cycle
//   wb_tag             tag of that result
//   wb_src[1:0]        result mux select: 00 fneg, 01 add/sub, 10 mul, 11 div
//   busy               any op in flight or divider occupied
//   illegal            one-cycle pulse after an unsupported op was accepted
//
// Configuration:
//   FPU_DIV_EN         when defined, fdiv is supported and the divider
//                      occupancy counter is built; otherwise 1110 is illegal.

module fpu_wb_scheduler #(
  parameter int LAT_ADD = 7,
  parameter int LAT_MUL = 6,
  parameter int LAT_DIV = 6,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [3:0]       issue_op,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ready,
  output logic             stall,
  input  logic             flush,
  output logic             addsub_sel,
  output logic             wb_valid,
  output logic [TAG_W-1:0] wb_tag,
  output logic [1:0]       wb_src,
  output logic             busy,
  output logic             illegal
);

  localparam int NSLOT = 16;

  localparam logic [3:0] OP_FNEG = 4'b1010;
  localparam logic [3:0] OP_FADD = 4'b1011;
  localparam logic [3:0] OP_FSUB = 4'b1100;
  localparam logic [3:0] OP_FMUL = 4'b1101;

  localparam logic [1:0] SRC_NEG = 2'b00;
  localparam logic [1:0] SRC_ADD = 2'b01;
  localparam logic [1:0] SRC_MUL = 2'b10;

  localparam logic [3:0] LAT_ADD_L = 4'(LAT_ADD);
  localparam logic [3:0] LAT_MUL_L = 4'(LAT_MUL);

`ifdef FPU_DIV_EN
  localparam logic [3:0] OP_FDIV   = 4'b1110;
  localparam logic [1:0] SRC_DIV   = 2'b11;
  localparam logic [3:0] LAT_DIV_L = 4'(LAT_DIV);
`endif

  // A latency outside 1..15 would index past the slot array.
  if (LAT_ADD < 1 || LAT_ADD > 15 || LAT_MUL < 1 || LAT_MUL > 15 ||
      LAT_DIV < 1 || LAT_DIV > 15) begin : g_lat_check
    $error("fpu_wb_scheduler: latencies must lie in 1..15");
  end

  // ---------------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------------
  logic       op_legal;
  logic [3:0] op_lat;
  logic [1:0] op_src;
`ifdef FPU_DIV_EN
  logic       op_is_div;
`endif

  always_comb begin
    op_legal = 1'b1;
    op_lat   = 4'd1;
    op_src   = SRC_NEG;
`ifdef FPU_DIV_EN
    op_is_div = 1'b0;
`endif
    case (issue_op)
      OP_FNEG: begin
        op_lat = 4'd1;
        op_src = SRC_NEG;
      end
      OP_FADD, OP_FSUB: begin
        op_lat = LAT_ADD_L;
        op_src = SRC_ADD;
      end
      OP_FMUL: begin
        op_lat = LAT_MUL_L;
        op_src = SRC_MUL;
      end
`ifdef FPU_DIV_EN
      OP_FDIV: begin
        op_lat    = LAT_DIV_L;
        op_src    = SRC_DIV;
        op_is_div = 1'b1;
      end
`endif
      default: op_legal = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Writeback slot wheel
  // ---------------------------------------------------------------------------
  logic [NSLOT-1:0] slot_v;
  logic [TAG_W-1:0] slot_tag [NSLOT];
  logic [1:0]       slot_src [NSLOT];

  logic       port_conflict;
  logic       div_block;
  logic       div_active;
  logic       accept;
  logic [3:0] slot_idx;

  // Slot L shifts into L-1 at this edge, which is exactly where the new op
  // would land, so an occupied s[L] means the port is already booked. Illegal
  // ops reserve nothing and therefore never conflict.
  assign port_conflict = op_legal & slot_v[op_lat];
  assign slot_idx      = op_lat - 4'd1;

`ifdef FPU_DIV_EN
  logic [3:0] div_cnt;

  // div_cnt == 1 is the cycle the previous quotient is on the writeback
  // port; the divider is free to start again at that edge, which gives one
  // fdiv every LAT_DIV cycles.
  assign div_block  = op_is_div & (div_cnt > 4'd1);
  assign div_active = (div_cnt != 4'd0);
`else
  assign div_block  = 1'b0;
  assign div_active = 1'b0;
`endif

  assign issue_ready = ~rst & ~flush & ~port_conflict & ~div_block;
  assign accept      = issue_valid & issue_ready;
  assign stall       = issue_valid & ~issue_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_v <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        slot_tag[k] <= '0;
        slot_src[k] <= '0;
      end
      addsub_sel <= 1'b1;
      illegal    <= 1'b0;
`ifdef FPU_DIV_EN
      div_cnt    <= '0;
`endif
    end else if (flush) begin
      // Flush drops everything in flight; accept is already low here so a
      // same-cycle issue is lost and addsub_sel keeps its value.
      slot_v <= '0;
      for (int k = 0; k < NSLOT; k++) begin
        slot_tag[k] <= '0;
        slot_src[k] <= '0;
      end
      illegal <= 1'b0;
`ifdef FPU_DIV_EN
      div_cnt <= '0;
`endif
    end else begin
      slot_v <= {1'b0, slot_v[NSLOT-1:1]};
      for (int k = 0; k < NSLOT - 1; k++) begin
        slot_tag[k] <= slot_tag[k+1];
        slot_src[k] <= slot_src[k+1];
      end
      slot_tag[NSLOT-1] <= '0;
      slot_src[NSLOT-1] <= '0;

      // Later non-blocking writes win, so the reservation lands after the shift.
      if (accept && op_legal) begin
        slot_v[slot_idx]   <= 1'b1;
        slot_tag[slot_idx] <= issue_tag;
        slot_src[slot_idx] <= op_src;
      end

      illegal <= accept & ~op_legal;

      if (accept && issue_op == OP_FADD) begin
        addsub_sel <= 1'b1;
      end else if (accept && issue_op == OP_FSUB) begin
        addsub_sel <= 1'b0;
      end

`ifdef FPU_DIV_EN
      if (accept && op_is_div) begin
        div_cnt <= LAT_DIV_L;
      end else if (div_cnt != 4'd0) begin
        div_cnt <= div_cnt - 4'd1;
      end
`endif
    end
  end

  assign wb_valid = slot_v[0];
  assign wb_tag   = slot_tag[0];
  assign wb_src   = slot_src[0];
  assign busy     = (|slot_v) | div_active;

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// tb/tb_fpu_wb_scheduler.sv - scoreboard bench for fpu_wb_scheduler
//
// Purpose: drives directed FP issue sequences; every accepted op pushes its
// expected writeback (edge number, tag, source) into a queue, and a monitor on
// the falling clock edge pops and compares whenever wb_valid is seen.
// Ports: none (top-level bench).

module tb_fpu_wb_scheduler;

  localparam logic [3:0] OP_FNEG = 4'b1010;
  localparam logic [3:0] OP_FADD = 4'b1011;
  localparam logic [3:0] OP_FSUB = 4'b1100;
  localparam logic [3:0] OP_FMUL = 4'b1101;
  localparam logic [3:0] OP_FDIV = 4'b1110;

  logic       clk;
  logic       rst;
  logic       issue_valid;
  logic [3:0] issue_op;
  logic [4:0] issue_tag;
  logic       issue_ready;
  logic       stall;
  logic       flush;
  logic       addsub_sel;
  logic       wb_valid;
  logic [4:0] wb_tag;
  logic [1:0] wb_src;
  logic       busy;
  logic       illegal;

  fpu_wb_scheduler #(
    .LAT_ADD(7),
    .LAT_MUL(6),
    .LAT_DIV(6),
    .TAG_W  (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .issue_tag  (issue_tag),
    .issue_ready(issue_ready),
    .stall      (stall),
    .flush      (flush),
    .addsub_sel (addsub_sel),
    .wb_valid   (wb_valid),
    .wb_tag     (wb_tag),
    .wb_src     (wb_src),
    .busy       (busy),
    .illegal    (illegal)
  );

  typedef struct {
    int         edge_no;
    logic [4:0] tag;
    logic [1:0] src;
  } exp_t;

  exp_t q[$];
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  int   ill_edge = -1;
  bit   mon_en   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference latency/source table for the configured build (0 = illegal).
  function automatic int lat_of(input logic [3:0] op);
    case (op)
      OP_FNEG: return 1;
      OP_FADD, OP_FSUB: return 7;
      OP_FMUL: return 6;
`ifdef FPU_DIV_EN
      OP_FDIV: return 6;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic logic [1:0] src_of(input logic [3:0] op);
    case (op)
      OP_FNEG: return 2'b00;
      OP_FADD, OP_FSUB: return 2'b01;
      OP_FMUL: return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // One cycle of stimulus. exp_rdy < 0 skips the ready check.
  task automatic cyc(input logic v, input logic [3:0] op, input logic [4:0] tg,
                     input logic fl, input int exp_rdy);
    exp_t e;
    int   lat;
    @(negedge clk);
    #1;
    issue_valid = v;
    issue_op    = op;
    issue_tag   = tg;
    flush       = fl;
    #1;
    if (exp_rdy >= 0) begin
      chk("issue_ready", issue_ready, exp_rdy[0]);
      chk("stall", stall, v & ~exp_rdy[0]);
    end
    if (fl) begin
      q.delete();
    end else if (v && exp_rdy == 1) begin
      lat = lat_of(op);
      if (lat > 0) begin
        e.edge_no = edge_cnt + lat;
        e.tag     = tg;
        e.src     = src_of(op);
        q.push_back(e);
      end else begin
        ill_edge = edge_cnt + 1;
      end
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [4:0] tg, input int exp_rdy);
    cyc(1'b1, op, tg, 1'b0, exp_rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'b0000, 5'd0, 1'b0, -1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst         = 1'b1;
    issue_valid = 1'b0;
    flush       = 1'b0;
    q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    int idx;
    if (mon_en) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].edge_no < edge_cnt) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_missing: tag %0d due after edge %0d never written back", q[i].tag, q[i].edge_no);
          q.delete(i);
        end
      end
      if (wb_valid === 1'b1) begin
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].edge_no == edge_cnt) idx = i;
        end
        if (idx < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL wb_unexpected: tag %0d src %0b after edge %0d, required no writeback", wb_tag, wb_src, edge_cnt);
        end else begin
          chk("wb_tag", wb_tag, q[idx].tag);
          chk("wb_src", wb_src, q[idx].src);
          q.delete(idx);
        end
      end
      chk("illegal", illegal, edge_cnt == ill_edge);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    issue_valid = 1'b1;
    issue_op    = OP_FADD;
    issue_tag   = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("ready_in_reset", issue_ready, 1'b0);
    chk("stall_in_reset", stall, 1'b1);
    rst         = 1'b0;
    issue_valid = 1'b0;
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_tag", wb_tag, 5'd0);
    chk("rst_wb_src", wb_src, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_addsub_sel", addsub_sel, 1'b1);
    mon_en = 1;

    // fneg then fsub on consecutive edges
    issue(OP_FNEG, 5'd7, 1);
    issue(OP_FSUB, 5'd8, 1);
    idle(1);
    chk("addsub_after_fsub", addsub_sel, 1'b0);
    idle(8);

    // single fadd
    issue(OP_FADD, 5'd3, 1);
    idle(1);
    chk("addsub_after_fadd", addsub_sel, 1'b1);
    chk("busy_fadd", busy, 1'b1);
    idle(8);
    chk("busy_idle", busy, 1'b0);

    // fadd then fmul: fmul needs slot 6 which fadd just took
    issue(OP_FADD, 5'd1, 1);
    issue(OP_FMUL, 5'd2, 0);
    issue(OP_FMUL, 5'd2, 1);
    idle(9);

    // fneg behind an fmul about to write back
    issue(OP_FMUL, 5'd15, 1);
    idle(4);
    issue(OP_FNEG, 5'd16, 0);
    issue(OP_FNEG, 5'd16, 1);
    idle(3);

    // back-to-back fadds at full throughput
    issue(OP_FADD, 5'd11, 1);
    issue(OP_FADD, 5'd12, 1);
    issue(OP_FADD, 5'd13, 1);
    idle(9);

`ifdef FPU_DIV_EN
    // divider occupancy: second fdiv waits until edge 6
    issue(OP_FDIV, 5'd4, 1);
    for (int i = 0; i < 5; i++) issue(OP_FDIV, 5'd5, 0);
    issue(OP_FDIV, 5'd5, 1);
    idle(1);
    chk("busy_div", busy, 1'b1);
    idle(12);
    // flush frees the divider immediately
    issue(OP_FDIV, 5'd20, 1);
    cyc(1'b0, 4'b0000, 5'd0, 1'b1, -1);
    issue(OP_FDIV, 5'd21, 1);
    idle(8);
`else
    // without the divider, fdiv is an illegal op
    issue(OP_FDIV, 5'd4, 1);
    idle(1);
    chk("busy_fdiv_illegal", busy, 1'b0);
    idle(3);
`endif

    // flush at edge 3 together with an fadd
    issue(OP_FMUL, 5'd9, 1);
    idle(2);
    cyc(1'b1, OP_FADD, 5'd10, 1'b1, 0);
    idle(1);
    chk("busy_after_flush", busy, 1'b0);
    chk("wb_after_flush", wb_valid, 1'b0);
    idle(8);

    // unsupported encoding
    issue(4'b0001, 5'd6, 1);
    idle(1);
    chk("busy_illegal", busy, 1'b0);
    idle(3);

    // reset mid-operation
    issue(OP_FMUL, 5'd14, 1);
    idle(2);
    do_reset();
    chk("busy_after_reset", busy, 1'b0);
    idle(10);

    idle(5);
    chk("scoreboard_drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
